// File: rtl/nx_ia_initPKG.sv
// Status codes, FSM states and helpers for nx_indirect_access_initiator.
package nx_ia_initPKG;
   import nx_mem_typePKG_v2::*;

   typedef enum logic [2:0] {
      STAT_RDY = 3'd0,
      STAT_BSY = 3'd1,
      STAT_TMO = 3'd2,
      STAT_OVR = 3'd3,
      STAT_NXM = 3'd4,
      STAT_UOP = 3'd5
   } stat_code_e;

   typedef enum logic [2:0] {
      IA_IDLE,
      IA_WDATA,
      IA_CMND,
      IA_POLL,
      IA_RESP
   } ia_init_state_e;

   localparam logic [3:0] IA_OP_MAX = 4'd8;

   function automatic logic ia_op_ok(input logic [3:0] op);
      return (op != CMND_NOP) && (op <= IA_OP_MAX);
   endfunction

   function automatic int ia_addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nx_mem_typePKG_v2.sv
// Command-op encodings shared by the nx memory wrappers' indirect-access ports.
package nx_mem_typePKG_v2;

   typedef enum logic [3:0] {
      CMND_NOP   = 4'd0,
      CMND_READ  = 4'd1,
      CMND_WRITE = 4'd2,
      CMND_INIT  = 4'd6
   } cmnd_op_e;

endpackage

// File: rtl/nx_indirect_access_initiator.sv
// Drives one indirect-access controller: data write, command write, status poll, response.
// Optional poll timeout is compiled in with `define NX_IA_INIT_TMO_EN.
module nx_indirect_access_initiator
   import nx_mem_typePKG_v2::*;
   import nx_ia_initPKG::*;
#(
   parameter int          N_REG_ADDR_BITS = 16,
   parameter int unsigned CMND_ADDRESS    = 0,
   parameter int unsigned DATA_ADDRESS    = 0,
   parameter int          N_DATA_BITS     = 32,
   parameter int          N_ENTRIES       = 1,
   parameter int          N_TMO_BITS      = 10
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [3:0]                      req_op,
   input  logic [ia_addr_w(N_ENTRIES)-1:0] req_addr,
   input  logic [N_DATA_BITS-1:0]          req_data,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [2:0]                      rsp_stat,
   output logic [N_DATA_BITS-1:0]          rsp_data,
   output logic [N_REG_ADDR_BITS-1:0]      reg_addr,
   output logic                            wr_stb,
   output logic [N_DATA_BITS-1:0]          wr_dat,
   output logic [3:0]                      cmnd_op,
   output logic [ia_addr_w(N_ENTRIES)-1:0] cmnd_addr,
   input  logic [2:0]                      stat_code,
   input  logic [N_DATA_BITS-1:0]          rd_dat
);

   localparam int AW = ia_addr_w(N_ENTRIES);
   localparam logic [N_REG_ADDR_BITS-1:0] CMND_A = N_REG_ADDR_BITS'(CMND_ADDRESS);
   localparam logic [N_REG_ADDR_BITS-1:0] DATA_A = N_REG_ADDR_BITS'(DATA_ADDRESS);

   ia_init_state_e state_q, state_d;
   logic [3:0]     op_q;
   logic [AW-1:0]  addr_q;
   logic           blank_q;
   logic           accept, op_bad, addr_bad, poll_done;
   logic [3:0]     src_op;
   logic [AW-1:0]  src_addr;

`ifdef NX_IA_INIT_TMO_EN
   logic [N_TMO_BITS-1:0] tmo_q;
   logic                  tmo_full;
   assign tmo_full = &tmo_q;

   // Free-running while in POLL, parked at zero elsewhere so every poll starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                tmo_q <= '0;
      else if (state_q != IA_POLL) tmo_q <= '0;
      else if (!tmo_full)        tmo_q <= tmo_q + 1'b1;
   end

   assign poll_done = !blank_q && ((stat_code != STAT_BSY) || tmo_full);
`else
   logic unused_tmo;
   assign unused_tmo = ^N_TMO_BITS;
   assign poll_done  = !blank_q && (stat_code != STAT_BSY);
`endif

   assign accept    = (state_q == IA_IDLE) && req_valid;
   assign op_bad    = !ia_op_ok(req_op);
   assign addr_bad  = int'(req_addr) > (N_ENTRIES - 1);
   assign src_op    = (state_q == IA_IDLE) ? req_op   : op_q;
   assign src_addr  = (state_q == IA_IDLE) ? req_addr : addr_q;
   assign req_ready = (state_q == IA_IDLE);
   assign rsp_valid = (state_q == IA_RESP);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IA_IDLE:
            if (accept) begin
               if (op_bad || addr_bad)        state_d = IA_RESP;
               else if (req_op == CMND_WRITE) state_d = IA_WDATA;
               else                           state_d = IA_CMND;
            end
         IA_WDATA: state_d = IA_CMND;
         IA_CMND:  state_d = IA_POLL;
         IA_POLL:  if (poll_done) state_d = IA_RESP;
         IA_RESP:  if (rsp_ready) state_d = IA_IDLE;
         default:  state_d = IA_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IA_IDLE;
         op_q      <= '0;
         addr_q    <= '0;
         blank_q   <= 1'b0;
         rsp_stat  <= '0;
         rsp_data  <= '0;
         wr_stb    <= 1'b0;
         reg_addr  <= '0;
         wr_dat    <= '0;
         cmnd_op   <= '0;
         cmnd_addr <= '0;
      end else begin
         state_q <= state_d;
         blank_q <= (state_q != IA_POLL);
         // Bus outputs are decoded from the next state so the strobe lines up with WDATA/CMND.
         wr_stb    <= (state_d == IA_WDATA) || (state_d == IA_CMND);
         reg_addr  <= (state_d == IA_WDATA) ? DATA_A :
                      (state_d == IA_CMND)  ? CMND_A : '0;
         wr_dat    <= (state_d == IA_WDATA) ? req_data : '0;
         cmnd_op   <= (state_d == IA_CMND)  ? src_op   : '0;
         cmnd_addr <= (state_d == IA_CMND)  ? src_addr : '0;
         if (accept) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            rsp_data <= '0;
            rsp_stat <= op_bad   ? STAT_UOP :
                        addr_bad ? STAT_NXM : STAT_RDY;
         end
         if ((state_q == IA_POLL) && (state_d == IA_RESP)) begin
            rsp_stat <= (stat_code != STAT_BSY) ? stat_code : STAT_TMO;
            rsp_data <= ((op_q == CMND_READ) && (stat_code == STAT_RDY)) ? rd_dat : '0;
         end
      end
   end

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Scoreboard bench for nx_indirect_access_initiator with a behavioural target model.
module tb_nx_indirect_access_initiator;

   localparam int          DW   = 32;
   localparam int          RAW  = 16;
   localparam int          NE   = 12;
   localparam int          AW   = 4;
   localparam int          TB   = 4;
   localparam int          TLIM = (1 << TB) - 1;
   localparam logic [15:0] CA   = 16'h0014;
   localparam logic [15:0] DA   = 16'h0010;

   logic           clk, rst_n;
   logic           req_valid, req_ready, rsp_valid, rsp_ready, wr_stb;
   logic [3:0]     req_op, cmnd_op;
   logic [AW-1:0]  req_addr, cmnd_addr;
   logic [DW-1:0]  req_data, rsp_data, wr_dat, rd_dat;
   logic [2:0]     rsp_stat, stat_code;
   logic [RAW-1:0] reg_addr;

   nx_indirect_access_initiator #(
      .N_REG_ADDR_BITS(RAW), .CMND_ADDRESS(32'(CA)), .DATA_ADDRESS(32'(DA)),
      .N_DATA_BITS(DW), .N_ENTRIES(NE), .N_TMO_BITS(TB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
      .reg_addr(reg_addr), .wr_stb(wr_stb), .wr_dat(wr_dat), .cmnd_op(cmnd_op),
      .cmnd_addr(cmnd_addr), .stat_code(stat_code), .rd_dat(rd_dat)
   );

   typedef struct packed { logic [15:0] ra; logic [31:0] wd; logic [3:0] op; logic [3:0] ad; bit is_cmnd; } stb_t;
   typedef struct packed { logic [2:0] st; logic [31:0] d; int lat; } rsp_t;
   typedef struct packed { int nbsy; logic [2:0] fs; logic [31:0] rd; } plan_t;

   stb_t  exp_stb[$];
   rsp_t  exp_rsp[$];
   plan_t tgt_q[$];
   plan_t p_plan, cur;
   int    errs = 0, checks = 0, cyc = 0, t_acc = 0, rr_mode = 0, tcnt = 0;
   bit    in_flight = 0, rsp_seen = 0, tact = 0;
   logic [34:0] held;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: response and bus traffic derived from the protocol rules.
   task automatic model_push(input logic [3:0] op, input logic [AW-1:0] ad,
                             input logic [31:0] dat, input plan_t pl);
      rsp_t r;
      stb_t s;
      int   base;
      r.d = '0;
      if (op == 4'd0 || op > 4'd8) begin
         r.st = 3'd5; r.lat = 1;
      end else if (int'(ad) >= NE) begin
         r.st = 3'd4; r.lat = 1;
      end else begin
         base = (op == 4'd2) ? 5 : 4;
         if (op == 4'd2) begin
            s.ra = DA; s.wd = dat; s.op = '0; s.ad = '0; s.is_cmnd = 0;
            exp_stb.push_back(s);
         end
         s.ra = CA; s.wd = '0; s.op = op; s.ad = ad; s.is_cmnd = 1;
         exp_stb.push_back(s);
         tgt_q.push_back(pl);
         r.st = pl.fs; r.lat = base + pl.nbsy;
         if (op == 4'd1 && pl.fs == 3'd0) r.d = pl.rd;
`ifdef NX_IA_INIT_TMO_EN
         if (pl.nbsy >= TLIM) begin
            r.st = 3'd2; r.lat = base + TLIM - 1; r.d = '0;
         end
`endif
      end
      exp_rsp.push_back(r);
   endtask

   // Target: BSY for the blanking cycle plus nbsy cycles after a command write, then final status.
   always @(negedge clk) begin
      if (!rst_n) begin
         tact = 0; stat_code = 3'd0; rd_dat = '0;
      end else if (wr_stb && reg_addr == CA) begin
         if (tgt_q.size() > 0) cur = tgt_q.pop_front();
         tact = 1; tcnt = cur.nbsy + 1; stat_code = 3'd1; rd_dat = $urandom;
      end else if (tact) begin
         if (tcnt > 0) begin
            tcnt--; stat_code = 3'd1; rd_dat = $urandom;
         end else begin
            stat_code = cur.fs; rd_dat = cur.rd;
         end
      end else begin
         stat_code = 3'($urandom_range(0, 5)); rd_dat = $urandom;
      end
   end

   always @(posedge clk) begin
      #1;
      case (rr_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom_range(0, 1));
         default: rsp_ready = 1'b0;
      endcase
   end

   // Monitor: bus traffic, response fields, latency, hold stability, single-outstanding rule.
   always @(negedge clk) begin
      if (rst_n) begin
         stb_t s;
         rsp_t e;
         chk("req_ready", 64'(req_ready), 64'(!in_flight));
         if (wr_stb) begin
            if (exp_stb.size() == 0) begin
               checks++; errs++;
               $display("FAIL strobe: got unexpected strobe reg_addr=%0h expected none", reg_addr);
            end else begin
               s = exp_stb.pop_front();
               chk("stb_reg_addr", 64'(reg_addr), 64'(s.ra));
               if (s.is_cmnd) begin
                  chk("stb_cmnd_op", 64'(cmnd_op), 64'(s.op));
                  chk("stb_cmnd_addr", 64'(cmnd_addr), 64'(s.ad));
               end else chk("stb_wr_dat", 64'(wr_dat), 64'(s.wd));
            end
         end else chk("idle_bus", {8'h0, reg_addr, wr_dat, cmnd_op, cmnd_addr}, 64'h0);
         if (rsp_valid) begin
            if (!rsp_seen) begin
               rsp_seen = 1;
               held = {rsp_stat, rsp_data};
               if (exp_rsp.size() == 0) begin
                  checks++; errs++;
                  $display("FAIL rsp: got unexpected response stat=%0d expected none", rsp_stat);
               end else begin
                  e = exp_rsp.pop_front();
                  chk("rsp_stat", 64'(rsp_stat), 64'(e.st));
                  chk("rsp_data", 64'(rsp_data), 64'(e.d));
                  chk("latency", 64'(cyc - t_acc), 64'(e.lat));
                  chk("strobes_done", 64'(exp_stb.size()), 64'h0);
               end
            end else chk("rsp_hold", 64'({rsp_stat, rsp_data}), 64'(held));
            if (rsp_ready) begin
               rsp_seen = 0; in_flight = 0;
            end
         end
         if (req_valid && req_ready) begin
            in_flight = 1; t_acc = cyc;
         end
      end
   end

   task automatic drive_req(input logic [3:0] op, input logic [AW-1:0] ad,
                            input logic [31:0] dat, input int nb, input logic [2:0] fs,
                            input logic [31:0] rdv);
      req_op = op; req_addr = ad; req_data = dat;
      p_plan.nbsy = nb; p_plan.fs = fs; p_plan.rd = rdv;
      req_valid = 1'b1;
   endtask

   task automatic wait_accept();
      bit ok = 0;
      int n = 0;
      while (!ok && n < 600) begin
         @(negedge clk);
         if (req_ready) ok = 1;
         n++;
      end
      if (ok) model_push(req_op, req_addr, req_data, p_plan);
      else begin
         checks++; errs++;
         $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected accept", n);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [AW-1:0] ad, input logic [31:0] dat,
                       input int nb, input logic [2:0] fs, input logic [31:0] rdv);
      drive_req(op, ad, dat, nb, fs, rdv);
      wait_accept();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((in_flight || exp_rsp.size() != 0) && n < 600) begin
         @(negedge clk); n++;
      end
      if (n >= 600) begin
         checks++; errs++;
         $display("FAIL idle_timeout: got in_flight=%0d pending=%0d expected drained", in_flight, exp_rsp.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 64'(req_ready), 64'h1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp", 64'({rsp_stat, rsp_data}), 64'h0);
      chk("rst_bus", {7'h0, wr_stb, reg_addr, wr_dat, cmnd_op, cmnd_addr}, 64'h0);
   endtask

   initial begin
      logic [3:0] ops [8];
      logic [2:0] fss [6];
      ops = '{4'd1, 4'd2, 4'd6, 4'd0, 4'd9, 4'd3, 4'd15, 4'd1};
      fss = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd2};
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      send(4'd2, 4'd3, 32'hDEADBEEF, 2, 3'd0, 32'h0);          wait_idle();
      send(4'd1, 4'd5, 32'h0, 0, 3'd0, 32'h12345678);          wait_idle();
      send(4'd6, 4'd7, 32'h0, 0, 3'd0, 32'hA5A5A5A5);          wait_idle();
      send(4'd2, 4'd0, 32'h0BADF00D, 0, 3'd0, 32'h0);          wait_idle();
      send(4'd1, 4'(NE), 32'h0, 0, 3'd0, 32'h0);               wait_idle();
      send(4'd1, 4'd15, 32'h0, 0, 3'd0, 32'h0);                wait_idle();
      send(4'd9, 4'd1, 32'h0, 0, 3'd0, 32'h0);                 wait_idle();
      send(4'd0, 4'd1, 32'h0, 0, 3'd0, 32'h0);                 wait_idle();
      send(4'd1, 4'(NE - 1), 32'h0, 1, 3'd3, 32'hFFFF0000);    wait_idle();

      // Response stalled with the next request already waiting.
      rr_mode = 2;
      send(4'd1, 4'd2, 32'h0, 0, 3'd0, 32'hAAAA5555);
      drive_req(4'd2, 4'd4, 32'h00000055, 0, 3'd0, 32'h0);
      repeat (14) @(posedge clk);
      #1;
      rr_mode = 0;
      wait_accept();
      wait_idle();

      rr_mode = 1;
      for (int i = 0; i < 40; i++) begin
         send(ops[$urandom_range(0, 7)], 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3), fss[$urandom_range(0, 5)], $urandom);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_idle();
      rr_mode = 0;

`ifdef NX_IA_INIT_TMO_EN
      send(4'd1, 4'd1, 32'h0, 100, 3'd0, 32'h0);               wait_idle();
      send(4'd2, 4'd2, 32'h1234, TLIM - 1, 3'd0, 32'h0);       wait_idle();
      send(4'd6, 4'd3, 32'h0, TLIM, 3'd0, 32'h0);              wait_idle();
`endif

      // Reset pulsed while polling a stuck-busy target.
      send(4'd1, 4'd6, 32'h0, 1000, 3'd0, 32'h0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      exp_stb.delete(); exp_rsp.delete(); tgt_q.delete();
      in_flight = 0; rsp_seen = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(4'd1, 4'd5, 32'h0, 0, 3'd0, 32'hC0FFEE00);          wait_idle();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
